// File: rtl/jtppi_fifo.sv
// NPORT-port parallel peripheral interface with per-port mode select and a
// DEPTH-entry FIFO behind the strobed input/output handshakes.
module jtppi_fifo #(
  parameter int NPORT = 4,
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [$clog2(NPORT)+1:0]   addr,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  input  logic                       rdn,
  input  logic                       wrn,
  input  logic                       csn,
  input  logic [NPORT*W-1:0]         port_din,
  output logic [NPORT*W-1:0]         port_dout,
  output logic [NPORT-1:0]           port_oe,
  input  logic [NPORT-1:0]           hs_in,
  output logic [NPORT-1:0]           hs_out,
  output logic                       irq
);

  localparam int PW = $clog2(NPORT);
  localparam int AW = PW + 2;
  localparam int DW = $clog2(DEPTH);
  localparam int CW = DW + 1;

  localparam logic [1:0] MODE_IN   = 2'd0;
  localparam logic [1:0] MODE_OUT  = 2'd1;
  localparam logic [1:0] MODE_SIN  = 2'd2;
  localparam logic [1:0] MODE_SOUT = 2'd3;

  logic          rd, wr, rd_q, wr_q, commit;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [W-1:0]  wr_data;
  logic [2:0]    wd3;

  logic [1:0]    mode  [NPORT];
  logic [W-1:0]  latch [NPORT];
  logic [DW-1:0] rp    [NPORT];
  logic [DW-1:0] wp    [NPORT];
  logic [CW-1:0] cnt   [NPORT];
  logic [W-1:0]  mem   [NPORT][DEPTH];
  logic [NPORT-1:0] ie, ovf, hs_q;

  logic [NPORT-1:0] nonempty, full, ctl_wr, dat_wr, sts_wr;
  logic [NPORT-1:0] push, pop, ovf_set, hs_rise, pend;
  logic [W-1:0]     push_data [NPORT];
  logic [W-1:0]     head      [NPORT];

  logic [PW-1:0] rd_port;
  logic [7:0]    status8;
  logic [W-1:0]  rd_val;

  assign rd     = !rdn && !csn;
  assign wr     = !wrn && !csn;
  assign commit = wr_q && !wr;
  assign wd3    = 3'(wr_data);

  // Bus capture: writes commit on the trailing edge with the values held
  // during the strobe, and the read address is kept for the trailing-edge pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rd_addr <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      dout    <= '1;
    end else begin
      rd_q <= rd;
      wr_q <= wr;
      if (wr) begin
        wr_addr <= addr;
        wr_data <= din;
      end
      if (rd) begin
        rd_addr <= addr;
        dout    <= rd_val;
      end
    end
  end

  // Per-port request decode: who pushes, who pops, and what gets dropped.
  always_comb begin
    for (int p = 0; p < NPORT; p++) begin
      nonempty[p]  = cnt[p] != '0;
      full[p]      = cnt[p] == CW'(DEPTH);
      head[p]      = mem[p][rp[p]];
      hs_rise[p]   = hs_in[p] && !hs_q[p];
      ctl_wr[p]    = commit && wr_addr[AW-1:2] == PW'(p) && wr_addr[1:0] == 2'd1;
      dat_wr[p]    = commit && wr_addr[AW-1:2] == PW'(p) && wr_addr[1:0] == 2'd0;
      sts_wr[p]    = commit && wr_addr[AW-1:2] == PW'(p) && wr_addr[1:0] == 2'd2;
      push[p]      = 1'b0;
      pop[p]       = 1'b0;
      ovf_set[p]   = 1'b0;
      push_data[p] = port_din[p*W +: W];
      pend[p]      = ie[p] && ((mode[p] == MODE_SIN && nonempty[p]) ||
                               (mode[p] == MODE_SOUT && !full[p]));
      if (!ctl_wr[p]) begin
        if (mode[p] == MODE_SIN) begin
          push[p]    = hs_rise[p] && !full[p];
          ovf_set[p] = hs_rise[p] && full[p];
          pop[p]     = rd_q && !rd && rd_addr[AW-1:2] == PW'(p) &&
                       rd_addr[1:0] == 2'd0 && nonempty[p];
        end else if (mode[p] == MODE_SOUT) begin
          push_data[p] = wr_data;
          push[p]      = dat_wr[p] && !full[p];
          ovf_set[p]   = dat_wr[p] && full[p];
          pop[p]       = hs_rise[p] && nonempty[p];
        end
      end
    end
  end

  // Port state; a control write reinitialises the port ahead of everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      ie     <= '0;
      ovf    <= '0;
      hs_q   <= '0;
      hs_out <= '0;
      irq    <= 1'b0;
      for (int p = 0; p < NPORT; p++) begin
        mode[p]  <= MODE_IN;
        latch[p] <= '0;
        rp[p]    <= '0;
        wp[p]    <= '0;
        cnt[p]   <= '0;
      end
    end else begin
      hs_q <= hs_in;
      irq  <= |pend;
      for (int p = 0; p < NPORT; p++) begin
        if (ctl_wr[p]) begin
          mode[p]   <= wd3[1:0];
          ie[p]     <= wd3[2];
          ovf[p]    <= 1'b0;
          latch[p]  <= '0;
          rp[p]     <= '0;
          wp[p]     <= '0;
          cnt[p]    <= '0;
          hs_out[p] <= 1'b0;
        end else begin
          hs_out[p] <= mode[p][1] && nonempty[p];
          if (push[p]) wp[p] <= wp[p] + 1'b1;
          if (pop[p])  rp[p] <= rp[p] + 1'b1;
          cnt[p] <= cnt[p] + CW'(push[p]) - CW'(pop[p]);
          if (ovf_set[p])
            ovf[p] <= 1'b1;
          else if (sts_wr[p] && wd3[2])
            ovf[p] <= 1'b0;
          if ((dat_wr[p] && mode[p] == MODE_OUT) ||
              (push[p] && mode[p] == MODE_SOUT))
            latch[p] <= wr_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < NPORT; p++) begin
      if (push[p]) mem[p][wp[p]] <= push_data[p];
    end
  end

  // CPU read mux; dout registers this only while the read strobe is active.
  always_comb begin
    rd_port = addr[AW-1:2];
    status8 = {4'(cnt[rd_port]), hs_in[rd_port], ovf[rd_port],
               full[rd_port], nonempty[rd_port]};
    rd_val  = '1;
    case (addr[1:0])
      2'd0: begin
        case (mode[rd_port])
          MODE_IN:  rd_val = port_din[rd_port*W +: W];
          MODE_SIN: rd_val = nonempty[rd_port] ? head[rd_port] : '1;
          default:  rd_val = latch[rd_port];
        endcase
      end
      2'd1:    rd_val = W'({5'b0, ie[rd_port], mode[rd_port]});
      2'd2:    rd_val = W'(status8);
      default: rd_val = W'(pend);
    endcase
  end

  always_comb begin
    port_dout = '0;
    port_oe   = '0;
    for (int p = 0; p < NPORT; p++) begin
      port_oe[p] = mode[p][0];
      if (mode[p] == MODE_OUT)
        port_dout[p*W +: W] = latch[p];
      else if (mode[p] == MODE_SOUT && nonempty[p])
        port_dout[p*W +: W] = head[p];
    end
  end

endmodule

// File: doc/jtppi_fifo.md
# jtppi_fifo

Parametrised parallel peripheral interface for CPU-side I/O expansion in the core. It is the successor to the fixed three-port 8255-style block. It provides NPORT ports of W bits, each independently configurable as plain input, plain output, strobed input or strobed output. Strobed modes buffer data in a per-port FIFO of DEPTH entries, with handshake pins and interrupts. It sits between the CPU bus decoder and board peripherals (joysticks, sound latches, sub-CPU mailboxes).

## Interface
- NPORT, 4, number of ports; power of two, 2..8
- W, 8, port and CPU data width, 1..8
- DEPTH, 4, FIFO entries per port; power of two, 2..8
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- addr  in  clog2(NPORT)+2  {port index, register select[1:0]}
- din  in  W  CPU write data
- dout  out  W  CPU read data, registered
- rdn, wrn, csn  in  1 each  active-low bus strobes; read = !rdn&!csn, write = !wrn&!csn
- port_din  in  NPORT*W  peripheral input data; port p at [p*W+:W]
- port_dout  out  NPORT*W  peripheral output data
- port_oe  out  NPORT  1 = port p drives its pins (modes 1, 3)
- hs_in  in  NPORT  STB (mode 2) / ACK (mode 3), synchronous to clk, active on rising edge
- hs_out  out  NPORT  IBF (mode 2) / OBF (mode 3), active high
- irq  out  1  OR of per-port pending interrupts

## Operation
- Registers per port (select): 0 data, 1 control, 2 status, 3 global irq vector (read-only, bit p = port p pending).
- Control: [1:0] mode (0 basic in, 1 basic out, 2 strobed in, 3 strobed out), [2] ie. Reads return {0, ie, mode}.
- Any control write flushes that port's FIFO, clears overflow and its output latch, and sets hs_out=0.
- Status: [0] nonempty, [1] full, [2] overflow (sticky), [3] hs_in level, [7:4] FIFO count (truncated to W). Writing 1 to bit 2 clears overflow.
- Data write, mode 1: update the latch; port_dout = latch.
- Data write, mode 3: push to the FIFO; if full, drop the data and set overflow.
- Data write, modes 0/2: ignored.
- Data read, mode 0: port_din. Mode 1: latch.
- Data read, mode 2: FIFO head, or all-ones if empty; the pop occurs at read trailing edge.
- Data read, mode 3: latch of last pushed value.
- Mode 2: an hs_in rising edge pushes port_din sampled in the same cycle. If full, the data is dropped and overflow is set. hs_out = nonempty.
- Mode 3: port_dout = FIFO head (all-zeros when empty), hs_out = nonempty. An hs_in rising edge pops; it is ignored when empty.
- Interrupt for port p: ie & ((mode2 & nonempty) | (mode3 & !full)), with no extra term for overflow.
- FIFO: read/write pointers wrap modulo DEPTH, and the count is 0..DEPTH. A simultaneous push and pop both take effect, leaving count unchanged. A pop on empty never happens in the same cycle as a push (a pop requires nonempty before the cycle).
- Out-of-range port index (≥NPORT cannot occur since NPORT is a power of two). Register 3 is identical for every index.

## Timing
- Reset: all ports mode 0, ie=0, FIFOs empty, overflow 0, latches 0. port_dout=0, port_oe=0, hs_out=0, irq=0, dout=all-ones.
- Write: addr/din are captured every cycle write is asserted. The commit happens in the first cycle write is low after being high, using the captured values; effects are visible on the following cycle.
- Read: dout updates every cycle read is asserted (1-cycle latency). The FIFO pop happens on the cycle read deasserts, using addr captured during the read, so dout is stable for the whole access.
- hs_in: registered once for edge detection. A push/pop takes effect one cycle after the rising edge; hs_out and irq follow one cycle later.
- A reset asserted mid-access or mid-handshake returns all state to reset values on the next edge. Pending edges are lost.
- A CPU pop and an hs_in push on the same port in the same cycle are both honoured.

## Test plan
- Reset, then read port 1 control/status -> 0x00 / 0x00 status count, dout before any read = all-ones, irq=0.
- Port 0 mode 2, ie=1; pulse hs_in[0] with port_din=0x5A then 0xA5 -> hs_out[0]=1, irq=1, status count=2. Two data reads return 0x5A, 0xA5; after the second trailing edge, irq=0.
- Port 2 mode 3, DEPTH=4; write 5 bytes 0x10..0x14 -> full=1, overflow=1. Pulse ack 4× -> port_dout steps 0x10..0x13, then hs_out=0.
- Port 3 mode 1; write 0xC3 -> port_oe[3]=1, port_dout[3]=0xC3. Write mode 0 -> port_oe[3]=0, data reads track port_din.
- Mode 2 with FIFO at count 1; CPU read trailing edge coincides with an hs_in push -> count stays 1, the head becomes the new value.
- Assert rst during a held wrn to mode 3 -> no commit; all outputs return to reset values.
